// File: rtl/mse_seq_ctrl.sv
// Sequencing controller for a 4-lane MSE datapath: feeds word pairs, tracks latency, accumulates a pixel total.
// Optional build macro MSE_SEQ_CTRL_SAT_EN: saturating accumulator with overflow reported on err.
module mse_seq_ctrl #(
  parameter int DATA_WIDTH     = 16,
  parameter int WORD_WIDTH     = DATA_WIDTH * 4,
  parameter int DATA_WIDTH_SUM = 32,
  parameter int ACC_WIDTH      = 48,
  parameter int CNT_WIDTH      = 8,
  parameter int DP_LATENCY     = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [CNT_WIDTH-1:0]      num_words,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WORD_WIDTH-1:0]     in_vctr_1,
  input  logic [WORD_WIDTH-1:0]     in_vctr_2,
  output logic [WORD_WIDTH-1:0]     dp_vctr_1,
  output logic [WORD_WIDTH-1:0]     dp_vctr_2,
  input  logic [DATA_WIDTH_SUM-1:0] dp_sum,
  output logic [ACC_WIDTH-1:0]      acc_out,
  output logic                      acc_valid,
  output logic                      busy,
  output logic                      err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  state_t                r_state;
  logic [CNT_WIDTH-1:0]  r_num;
  logic [CNT_WIDTH-1:0]  r_cnt;
  // Stage 0 is aligned with dp_vctr_*; stage DP_LATENCY is aligned with dp_sum.
  logic [DP_LATENCY:0]   r_tok;
  logic [DP_LATENCY:0]   r_last;
  logic [ACC_WIDTH-1:0]  r_acc;
  logic [ACC_WIDTH-1:0]  r_acc_out;
  logic [WORD_WIDTH-1:0] r_v1;
  logic [WORD_WIDTH-1:0] r_v2;
  logic                  r_in_ready;
  logic                  r_acc_valid;
  logic                  r_busy;
  logic                  r_err;

  logic                  w_xfer;
  logic                  w_is_last;
  logic                  w_tok_out;
  logic                  w_last_out;
  logic [ACC_WIDTH-1:0]  w_acc_next;
  logic                  w_ovf_err;

  assign w_xfer     = in_valid & r_in_ready;
  assign w_is_last  = (r_cnt == (r_num - CNT_ONE));
  assign w_tok_out  = r_tok[DP_LATENCY];
  assign w_last_out = r_tok[DP_LATENCY] & r_last[DP_LATENCY];

`ifdef MSE_SEQ_CTRL_SAT_EN
  logic [ACC_WIDTH:0] w_sum_ext;
  assign w_sum_ext  = {1'b0, r_acc} + {{(ACC_WIDTH + 1 - DATA_WIDTH_SUM){1'b0}}, dp_sum};
  assign w_ovf_err  = w_sum_ext[ACC_WIDTH];
  assign w_acc_next = w_sum_ext[ACC_WIDTH] ? {ACC_WIDTH{1'b1}} : w_sum_ext[ACC_WIDTH-1:0];
`else
  assign w_acc_next = r_acc + {{(ACC_WIDTH - DATA_WIDTH_SUM){1'b0}}, dp_sum};
  assign w_ovf_err  = 1'b0;
`endif

  // Control FSM, token pipeline, accumulator and all registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_num       <= '0;
      r_cnt       <= '0;
      r_tok       <= '0;
      r_last      <= '0;
      r_acc       <= '0;
      r_acc_out   <= '0;
      r_v1        <= '0;
      r_v2        <= '0;
      r_in_ready  <= 1'b0;
      r_acc_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_acc_valid <= 1'b0;
      r_tok       <= {r_tok[DP_LATENCY-1:0], w_xfer};
      r_last      <= {r_last[DP_LATENCY-1:0], w_xfer & w_is_last};

      if (w_xfer) begin
        r_v1  <= in_vctr_1;
        r_v2  <= in_vctr_2;
        r_cnt <= r_cnt + CNT_ONE;
      end

      if (w_tok_out) begin
        r_acc <= w_acc_next;
        if (w_ovf_err) begin
          r_err <= 1'b1;
        end
      end

      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (num_words != '0) begin
              r_state    <= S_RUN;
              r_num      <= num_words;
              r_cnt      <= '0;
              r_acc      <= '0;
              r_in_ready <= 1'b1;
              r_busy     <= 1'b1;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (start) begin
            r_err <= 1'b1;
          end
          if (w_xfer && w_is_last) begin
            r_state    <= S_DRAIN;
            r_in_ready <= 1'b0;
          end
        end
        S_DRAIN: begin
          if (start) begin
            r_err <= 1'b1;
          end
          if (w_last_out) begin
            r_state     <= S_DONE;
            r_acc_out   <= w_acc_next;
            r_acc_valid <= 1'b1;
          end
        end
        S_DONE: begin
          if (start) begin
            r_err <= 1'b1;
          end
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state    <= S_IDLE;
          r_in_ready <= 1'b0;
          r_busy     <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign dp_vctr_1 = r_v1;
  assign dp_vctr_2 = r_v2;
  assign acc_out   = r_acc_out;
  assign acc_valid = r_acc_valid;
  assign busy      = r_busy;
  assign err       = r_err;

endmodule

// File: tb/tb_mse_seq_ctrl.sv
// Directed bench for mse_seq_ctrl with a 2-stage sum-of-squared-differences datapath model.
module tb_mse_seq_ctrl;

  localparam int DW  = 16;
  localparam int WW  = 64;
  localparam int SW  = 32;
  localparam int AW  = 33;
  localparam int CW  = 8;
  localparam int DPL = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [CW-1:0] num_words;
  logic          in_valid;
  logic          in_ready;
  logic [WW-1:0] in_vctr_1;
  logic [WW-1:0] in_vctr_2;
  logic [WW-1:0] dp_vctr_1;
  logic [WW-1:0] dp_vctr_2;
  logic [SW-1:0] dp_sum;
  logic [AW-1:0] acc_out;
  logic          acc_valid;
  logic          busy;
  logic          err;

  int checks   = 0;
  int failures = 0;

  // Word pairs: A gives 7, Z gives 0, H gives 100, M gives 2^32-1.
  localparam logic [WW-1:0] W_A1 = {16'd5, 16'd3, 16'd2, 16'd1};
  localparam logic [WW-1:0] W_A2 = {16'd3, 16'd2, 16'd1, 16'd0};
  localparam logic [WW-1:0] W_Z1 = {16'd9, 16'd8, 16'd7, 16'd6};
  localparam logic [WW-1:0] W_H1 = {16'd20, 16'd4, 16'd4, 16'd4};
  localparam logic [WW-1:0] W_H2 = {16'd10, 16'd4, 16'd4, 16'd4};
  localparam logic [WW-1:0] W_M1 = {16'd1, 16'd5, 16'd362, 16'd65535};
  localparam logic [WW-1:0] W_M2 = 64'd0;

  mse_seq_ctrl #(
    .DATA_WIDTH(DW), .WORD_WIDTH(WW), .DATA_WIDTH_SUM(SW),
    .ACC_WIDTH(AW), .CNT_WIDTH(CW), .DP_LATENCY(DPL)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .num_words(num_words),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_vctr_1(in_vctr_1), .in_vctr_2(in_vctr_2),
    .dp_vctr_1(dp_vctr_1), .dp_vctr_2(dp_vctr_2), .dp_sum(dp_sum),
    .acc_out(acc_out), .acc_valid(acc_valid), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  function automatic logic [SW-1:0] sqd(input logic [WW-1:0] a, input logic [WW-1:0] b);
    logic [33:0] s;
    logic [DW-1:0] d;
    s = 34'd0;
    for (int i = 0; i < 4; i++) begin
      d = (a[i*DW +: DW] > b[i*DW +: DW]) ? (a[i*DW +: DW] - b[i*DW +: DW])
                                          : (b[i*DW +: DW] - a[i*DW +: DW]);
      s = s + 34'(d * 32'(d));
    end
    return s[SW-1:0];
  endfunction

  logic [SW-1:0] p1 = '0;
  logic [SW-1:0] p2 = '0;
  always @(posedge clk) begin
    p1 <= sqd(dp_vctr_1, dp_vctr_2);
    p2 <= p1;
  end
  assign dp_sum = p2;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_start(input logic [CW-1:0] n);
    start     = 1'b1;
    num_words = n;
    tick();
    start     = 1'b0;
  endtask

  task automatic xfer(input logic [WW-1:0] a, input logic [WW-1:0] b);
    int n;
    n = 0;
    in_valid  = 1'b1;
    in_vctr_1 = a;
    in_vctr_2 = b;
    while (in_ready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check("xfer_ready", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_acc(input string tag);
    int n;
    n = 0;
    while (acc_valid !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    check(tag, 64'(n), 64'(DPL + 1));
  endtask

  task automatic count_pulses(input int cycles, output int pulses);
    pulses = 0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (acc_valid === 1'b1) pulses++;
    end
  endtask

  initial begin
    int pulses;
    rst = 1'b1; start = 1'b0; num_words = '0; in_valid = 1'b0;
    in_vctr_1 = '0; in_vctr_2 = '0;
    tick(); tick();
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_acc_valid", 64'(acc_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_acc_out", 64'(acc_out), 64'd0);
    check("rst_dp_vctr_1", dp_vctr_1, 64'd0);
    rst = 1'b0;
    tick();

    // Single word pixel
    do_start(8'd1);
    check("s1_busy", 64'(busy), 64'd1);
    check("s1_in_ready", 64'(in_ready), 64'd1);
    xfer(W_A1, W_A2);
    check("s1_ready_low", 64'(in_ready), 64'd0);
    check("s1_dp_vctr_1", dp_vctr_1, W_A1);
    check("s1_dp_vctr_2", dp_vctr_2, W_A2);
    wait_acc("s1_latency");
    check("s1_acc_out", 64'(acc_out), 64'd7);
    tick();
    check("s1_pulse_end", 64'(acc_valid), 64'd0);
    check("s1_busy_low", 64'(busy), 64'd0);

    // Three words back to back
    do_start(8'd3);
    xfer(W_A1, W_A2);
    xfer(W_Z1, W_Z1);
    xfer(W_H1, W_H2);
    check("s2_ready_low", 64'(in_ready), 64'd0);
    wait_acc("s2_latency");
    check("s2_acc_out", 64'(acc_out), 64'd107);
    tick();
    check("s2_busy_low", 64'(busy), 64'd0);
    tick(); tick();
    check("s2_dp_hold", dp_vctr_1, W_H1);
    check("s2_acc_hold", 64'(acc_out), 64'd107);

    // Three words with bubbles
    do_start(8'd3);
    xfer(W_A1, W_A2);
    tick(); tick();
    xfer(W_Z1, W_Z1);
    tick(); tick();
    xfer(W_H1, W_H2);
    wait_acc("s3_latency");
    check("s3_acc_out", 64'(acc_out), 64'd107);
    count_pulses(6, pulses);
    check("s3_extra_pulses", 64'(pulses), 64'd0);

    // Reset mid-pixel
    do_start(8'd3);
    xfer(W_A1, W_A2);
    xfer(W_Z1, W_Z1);
    rst = 1'b1;
    #1;
    check("s4_rst_busy", 64'(busy), 64'd0);
    check("s4_rst_in_ready", 64'(in_ready), 64'd0);
    check("s4_rst_acc_out", 64'(acc_out), 64'd0);
    check("s4_rst_dp_vctr", dp_vctr_1, 64'd0);
    tick();
    rst = 1'b0;
    count_pulses(8, pulses);
    check("s4_no_pulse", 64'(pulses), 64'd0);
    do_start(8'd1);
    xfer(W_A1, W_A2);
    wait_acc("s4_latency");
    check("s4_acc_out", 64'(acc_out), 64'd7);
    tick();

    // Error: zero-length start, then start while running
    check("s5_err_clear", 64'(err), 64'd0);
    do_start(8'd0);
    check("s5_err_zero", 64'(err), 64'd1);
    check("s5_idle", 64'(busy), 64'd0);
    do_start(8'd2);
    xfer(W_A1, W_A2);
    do_start(8'd5);
    check("s5_err_busy", 64'(err), 64'd1);
    check("s5_still_busy", 64'(busy), 64'd1);
    xfer(W_H1, W_H2);
    wait_acc("s5_latency");
    check("s5_acc_out", 64'(acc_out), 64'd107);
    tick();

    // Large sums near the accumulator limit
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    check("s6_err_cleared", 64'(err), 64'd0);
    do_start(8'd2);
    xfer(W_M1, W_M2);
    xfer(W_M1, W_M2);
    wait_acc("s6_latency");
    check("s6_acc_out", 64'(acc_out), 64'h1_FFFF_FFFE);
    check("s6_err", 64'(err), 64'd0);
    tick();

    do_start(8'd3);
    xfer(W_M1, W_M2);
    xfer(W_M1, W_M2);
    xfer(W_M1, W_M2);
    wait_acc("s7_latency");
`ifdef MSE_SEQ_CTRL_SAT_EN
    check("s7_acc_out_sat", 64'(acc_out), 64'h1_FFFF_FFFF);
    check("s7_err_sat", 64'(err), 64'd1);
`else
    check("s7_acc_out_wrap", 64'(acc_out), 64'h0_FFFF_FFFD);
    check("s7_err_wrap", 64'(err), 64'd0);
`endif
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
